// File: rtl/btb_repl_ctrl.sv
// Replacement/state controller for a 2-way BTB: per-set valid and LRU victim bits,
// lookup/update arbitration, miss allocation, and a sequenced invalidate sweep.
module btb_repl_ctrl #(
    parameter int SETS  = 8,
    parameter int IDX_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rd_en,
    input  logic [IDX_W-1:0]    rd_index,
    input  logic                rd_hit,
    input  logic                rd_way,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_index,
    input  logic                wr_hit,
    input  logic                wr_way,
    output logic                alloc_way,
    input  logic                flush_req,
    output logic                flush_busy,
    output logic                flush_done,
    output logic [2*SETS-1:0]   valid_out,
    output logic [SETS-1:0]     lru_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_r;
    logic [IDX_W-1:0]    ptr_r;
    logic [2*SETS-1:0]   valid_r;
    logic [SETS-1:0]     lru_r;
    logic                flush_busy_r;
    logic                flush_done_r;
    logic                alloc_way_s;
    logic                rd_touch_s;

    // Allocation way for the EX update: hit way, first invalid way, else LRU victim.
    always_comb begin
        alloc_way_s = 1'b0;
        if (wr_hit) begin
            alloc_way_s = wr_way;
        end else if (!valid_r[{wr_index, 1'b0}]) begin
            alloc_way_s = 1'b0;
        end else if (!valid_r[{wr_index, 1'b1}]) begin
            alloc_way_s = 1'b1;
        end else begin
            alloc_way_s = lru_r[wr_index];
        end
    end

    // A lookup touch is dropped when the update targets the same set.
    always_comb begin
        rd_touch_s = 1'b0;
        if (rd_en && rd_hit && !(wr_en && (wr_index == rd_index))) begin
            rd_touch_s = 1'b1;
        end else begin
            rd_touch_s = 1'b0;
        end
    end

    // Sweep FSM plus valid/LRU state updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            ptr_r        <= {IDX_W{1'b0}};
            valid_r      <= {(2*SETS){1'b0}};
            lru_r        <= {SETS{1'b0}};
            flush_busy_r <= 1'b0;
            flush_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    flush_done_r <= 1'b0;
                    if (flush_req) begin
                        state_r      <= ST_SWEEP;
                        ptr_r        <= {IDX_W{1'b0}};
                        flush_busy_r <= 1'b1;
                    end else begin
                        if (wr_en) begin
                            if (wr_hit) begin
                                lru_r[wr_index] <= ~wr_way;
                            end else begin
                                valid_r[{wr_index, alloc_way_s}] <= 1'b1;
                                lru_r[wr_index]                  <= ~alloc_way_s;
                            end
                        end
                        if (rd_touch_s) begin
                            lru_r[rd_index] <= ~rd_way;
                        end
                    end
                end
                ST_SWEEP: begin
                    valid_r[{ptr_r, 1'b0}] <= 1'b0;
                    valid_r[{ptr_r, 1'b1}] <= 1'b0;
                    lru_r[ptr_r]           <= 1'b0;
                    if (ptr_r == IDX_W'(SETS - 1)) begin
                        state_r      <= ST_DONE;
                        flush_done_r <= 1'b1;
                    end else begin
                        ptr_r <= ptr_r + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    state_r      <= ST_IDLE;
                    flush_busy_r <= 1'b0;
                    flush_done_r <= 1'b0;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    flush_busy_r <= 1'b0;
                    flush_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign alloc_way  = alloc_way_s;
    assign flush_busy = flush_busy_r;
    assign flush_done = flush_done_r;
    assign valid_out  = valid_r;
    assign lru_out    = lru_r;

endmodule

// File: tb/tb_btb_repl_ctrl.sv
// Self-checking bench for btb_repl_ctrl: directed scenarios plus random traffic
// compared against a set/way array model with a countdown-style flush model.
module tb_btb_repl_ctrl;
    localparam int SETS  = 8;
    localparam int IDX_W = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               rd_en, rd_hit, rd_way;
    logic               wr_en, wr_hit, wr_way;
    logic [IDX_W-1:0]   rd_index, wr_index;
    logic               alloc_way, flush_req, flush_busy, flush_done;
    logic [2*SETS-1:0]  valid_out;
    logic [SETS-1:0]    lru_out;

    int total = 0;
    int bad   = 0;

    // reference model
    bit mv [SETS][2];
    bit ml [SETS];
    int sweep_left;
    bit in_done;
    int done_seen;
    int busy_cnt;

    btb_repl_ctrl #(.SETS(SETS), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_en(rd_en), .rd_index(rd_index), .rd_hit(rd_hit), .rd_way(rd_way),
        .wr_en(wr_en), .wr_index(wr_index), .wr_hit(wr_hit), .wr_way(wr_way),
        .alloc_way(alloc_way), .flush_req(flush_req),
        .flush_busy(flush_busy), .flush_done(flush_done),
        .valid_out(valid_out), .lru_out(lru_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*SETS-1:0] exp_valid();
        logic [2*SETS-1:0] v;
        v = '0;
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < 2; w++)
                v[2*s+w] = mv[s][w];
        return v;
    endfunction

    function automatic logic [SETS-1:0] exp_lru();
        logic [SETS-1:0] v;
        for (int s = 0; s < SETS; s++) v[s] = ml[s];
        return v;
    endfunction

    function automatic bit model_alloc(input int idx, input bit hit, input bit way);
        if (hit)            return way;
        if (!mv[idx][0])    return 1'b0;
        if (!mv[idx][1])    return 1'b1;
        return ml[idx];
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            mv[s][0] = 1'b0; mv[s][1] = 1'b0; ml[s] = 1'b0;
        end
        sweep_left = 0;
        in_done    = 1'b0;
    endtask

    task automatic model_edge();
        bit a;
        int cs;
        if (in_done) begin
            in_done = 1'b0;
        end else if (sweep_left > 0) begin
            cs = SETS - sweep_left;
            mv[cs][0] = 1'b0; mv[cs][1] = 1'b0; ml[cs] = 1'b0;
            sweep_left--;
            if (sweep_left == 0) in_done = 1'b1;
        end else if (flush_req) begin
            sweep_left = SETS;
        end else begin
            a = model_alloc(int'(wr_index), wr_hit, wr_way);
            if (wr_en) begin
                if (wr_hit) ml[wr_index] = ~wr_way;
                else begin
                    mv[wr_index][a] = 1'b1;
                    ml[wr_index]    = ~a;
                end
            end
            if (rd_en && rd_hit && !(wr_en && wr_index == rd_index))
                ml[rd_index] = ~rd_way;
        end
    endtask

    task automatic idle_inputs();
        rd_en = 1'b0; rd_index = '0; rd_hit = 1'b0; rd_way = 1'b0;
        wr_en = 1'b0; wr_index = '0; wr_hit = 1'b0; wr_way = 1'b0;
        flush_req = 1'b0;
    endtask

    // inputs already driven; check comb output, clock once, check registered state
    task automatic step();
        #1;
        if (wr_en) check("alloc_way", alloc_way, model_alloc(int'(wr_index), wr_hit, wr_way));
        @(posedge clk);
        model_edge();
        #1;
        check("valid_out", valid_out, exp_valid());
        check("lru_out", lru_out, exp_lru());
        check("flush_busy", flush_busy, (sweep_left > 0) || in_done);
        check("flush_done", flush_done, in_done);
        if (flush_done) done_seen++;
        if (flush_busy) busy_cnt++;
    endtask

    task automatic wr(input int idx, input bit hit, input bit way);
        idle_inputs();
        wr_en = 1'b1; wr_index = IDX_W'(idx); wr_hit = hit; wr_way = way;
        step();
    endtask

    task automatic rand_io();
        rd_en = 1'($urandom); rd_index = IDX_W'($urandom); rd_hit = 1'($urandom); rd_way = 1'($urandom);
        wr_en = 1'($urandom); wr_index = IDX_W'($urandom); wr_hit = 1'($urandom); wr_way = 1'($urandom);
    endtask

    initial begin
        int d0;
        idle_inputs();
        done_seen = 0;
        busy_cnt  = 0;
        rst_n = 1'b0;
        model_reset();
        #12;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // T1: async reset mid-cycle clears everything immediately
        wr(1, 1'b0, 1'b0);
        wr(4, 1'b0, 1'b0);
        wr(4, 1'b0, 1'b0);
        idle_inputs();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t1_valid", valid_out, 32'h0);
        check("t1_lru", lru_out, 32'h0);
        check("t1_busy", flush_busy, 32'h0);
        check("t1_done", flush_done, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // T2: allocation order in set 3
        wr(3, 1'b0, 1'b0);
        wr(3, 1'b0, 1'b0);
        check("t2_valid", valid_out, 32'h00C0);
        idle_inputs();
        wr_en = 1'b1; wr_index = 3'd3;
        #1;
        check("t2_alloc_lru", alloc_way, 32'h0);
        step();

        // T3: touch via lookup then update
        wr(5, 1'b0, 1'b0);
        wr(5, 1'b0, 1'b0);
        idle_inputs();
        rd_en = 1'b1; rd_index = 3'd5; rd_hit = 1'b1; rd_way = 1'b0;
        step();
        check("t3_lru_rd", lru_out[5], 32'h1);
        wr(5, 1'b1, 1'b1);
        check("t3_lru_wr", lru_out[5], 32'h0);

        // T4: same-set collision (wr wins), then different sets
        idle_inputs();
        rd_en = 1'b1; rd_index = 3'd2; rd_hit = 1'b1; rd_way = 1'b1;
        wr_en = 1'b1; wr_index = 3'd2; wr_hit = 1'b1; wr_way = 1'b0;
        step();
        check("t4_same", lru_out[2], 32'h1);
        wr_index = 3'd6;
        step();
        check("t4_diff_rd", lru_out[2], 32'h0);
        check("t4_diff_wr", lru_out[6], 32'h1);

        // T5: fill everything, flush with traffic during sweep
        for (int s = 0; s < SETS; s++) begin
            wr(s, 1'b0, 1'b0);
            wr(s, 1'b0, 1'b0);
        end
        check("t5_full", valid_out, 32'hFFFF);
        idle_inputs();
        flush_req = 1'b1;
        busy_cnt = 0;
        d0 = done_seen;
        step();
        flush_req = 1'b0;
        for (int k = 0; k < SETS; k++) begin
            rand_io();
            flush_req = 1'($urandom);
            step();
        end
        check("t5_done_9th", flush_done, 32'h1);
        check("t5_valid0", valid_out, 32'h0);
        check("t5_lru0", lru_out, 32'h0);
        idle_inputs();
        step();
        check("t5_busy_cycles", busy_cnt, 32'd9);
        check("t5_done_once", done_seen - d0, 32'd1);

        // T6: reset during sweep aborts without done, then a full re-sweep
        for (int s = 0; s < SETS; s++) wr(s, 1'b0, 1'b0);
        idle_inputs();
        flush_req = 1'b1;
        d0 = done_seen;
        step();
        flush_req = 1'b0;
        for (int k = 0; k < 3; k++) step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_valid", valid_out, 32'h0);
        check("t6_busy", flush_busy, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) step();
        check("t6_no_done", done_seen - d0, 32'd0);
        for (int s = 0; s < SETS; s++) wr(s, 1'b0, 1'b1);
        idle_inputs();
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        for (int k = 0; k < SETS + 1; k++) step();
        check("t6_resweep_done", done_seen - d0, 32'd1);
        check("t6_resweep_valid", valid_out, 32'h0);

        // random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            rand_io();
            flush_req = ($urandom_range(0, 39) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
